// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl
// Multi-cycle multiply/divide unit with pipeline interlock for HI/LO.
// A request is accepted only in IDLE. Multiplies take MUL_LATENCY cycles.
// Divides use a restoring radix-2 divider on operand magnitudes and take
// 32 cycles. Divide-by-zero finishes after one cycle. A single DONE cycle
// pulses the HI/LO write enables.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   start_i     issue request from ID
//   op_i        00 mult, 01 multu, 10 div, 11 divu
//   a_i, b_i    rs / rt operands
//   hilo_rd_i   ID holds an mfhi/mflo
//   flush_i     abort any in-flight operation
//   busy_o      operation in flight (state != IDLE)
//   stall_o     freeze IF/ID while busy and ID needs the unit or HI/LO
//   done_o      one-cycle result-valid pulse
//   hi_wena_o   HI write enable
//   lo_wena_o   LO write enable
//   hi_o, lo_o  registered result data
//   div_zero_o  pulses with done_o when the divisor was zero
module muldiv_hilo_ctrl #(
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        hilo_rd_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        hi_wena_o,
  output logic        lo_wena_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_zero_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state;
  logic [3:0]  mul_cnt;
  logic [5:0]  div_cnt;
  logic        sgn_q;
  logic        dz_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        a_in_neg;
  logic [31:0] a_in_mag;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] b_mag;
  logic [63:0] prod;
  logic [32:0] shifted;
  logic        take;
  logic [31:0] step_rem;
  logic [31:0] step_quo;
  logic [31:0] quo_fin;
  logic [31:0] rem_fin;

  // The divider works on magnitudes. The dividend magnitude is loaded into
  // the quotient shift register at issue time. The divisor magnitude is
  // derived from the latched operand on every step.
  always_comb begin
    a_in_neg = ~op_i[0] & a_i[31];
    a_in_mag = a_in_neg ? (32'd0 - a_i) : a_i;
    a_neg    = sgn_q & a_q[31];
    b_neg    = sgn_q & b_q[31];
    b_mag    = b_neg ? (32'd0 - b_q) : b_q;
  end

  // Operands are sign- or zero-extended to 64 bits. The low 64 bits of the
  // product are then exact for both mult and multu.
  always_comb begin
    prod = {{32{a_neg}}, a_q} * {{32{b_neg}}, b_q};
  end

  // One restoring step. For divu the shifted partial remainder can reach
  // 33 bits, so the compare is done at 34 bits. The difference always fits
  // in 32 bits when the subtraction is taken.
  always_comb begin
    shifted  = {rem_q, quo_q[31]};
    take     = ({1'b0, shifted} >= {2'b00, b_mag});
    step_rem = take ? (shifted[31:0] - b_mag) : shifted[31:0];
    step_quo = {quo_q[30:0], take};
    quo_fin  = (a_neg ^ b_neg) ? (32'd0 - step_quo) : step_quo;
    rem_fin  = a_neg ? (32'd0 - step_rem) : step_rem;
  end

  // Flush takes priority over everything, including a same-cycle start.
  // HI/LO are loaded only on the transition into DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      mul_cnt <= '0;
      div_cnt <= '0;
      sgn_q   <= 1'b0;
      dz_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (flush_i) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            sgn_q <= ~op_i[0];
            if (op_i[1]) begin
              state   <= S_DIV;
              div_cnt <= '0;
              rem_q   <= '0;
              quo_q   <= a_in_mag;
              dz_q    <= (b_i == 32'd0);
            end else begin
              state   <= S_MUL;
              mul_cnt <= 4'(MUL_LATENCY - 1);
              dz_q    <= 1'b0;
            end
          end
        end
        S_MUL: begin
          if (mul_cnt == 4'd0) begin
            state <= S_DONE;
            hi_q  <= prod[63:32];
            lo_q  <= prod[31:0];
          end else begin
            mul_cnt <= mul_cnt - 4'd1;
          end
        end
        S_DIV: begin
          if (dz_q) begin
            state <= S_DONE;
            hi_q  <= a_q;
            lo_q  <= '1;
          end else begin
            rem_q   <= step_rem;
            quo_q   <= step_quo;
            div_cnt <= div_cnt + 6'd1;
            if (div_cnt == 6'd31) begin
              state <= S_DONE;
              hi_q  <= rem_fin;
              lo_q  <= quo_fin;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // A flush in DONE suppresses the write pulse for that cycle.
  always_comb begin
    busy_o     = (state != S_IDLE);
    stall_o    = busy_o & (start_i | hilo_rd_i);
    done_o     = (state == S_DONE) & ~flush_i;
    hi_wena_o  = done_o;
    lo_wena_o  = done_o;
    div_zero_o = done_o & dz_q;
    hi_o       = hi_q;
    lo_o       = lo_q;
  end

endmodule
